// File: rtl/button_bounce_gen.sv
// button_bounce_gen: turns a clean level request into a seeded, bouncing pushbutton waveform
module button_bounce_gen #(
    parameter int          CLK_FREQ     = 1_000,
    parameter int          SETTLE_HZ    = 100,
    parameter int          BOUNCE_PAIRS = 3,
    parameter int          GAP_BITS     = 2,
    parameter logic [15:0] SEED         = 16'hACE1,
    parameter logic        INIT_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level_in,
    output logic btn_out,
    output logic busy,
    output logic done
);
    localparam int          SETTLE_CYC = CLK_FREQ / SETTLE_HZ;
    localparam int          EDGES      = 2 * BOUNCE_PAIRS + 1;
    localparam int          EW         = $clog2(2 * BOUNCE_PAIRS + 2);
    localparam int          SW         = $clog2(SETTLE_CYC + 1);
    localparam int          GW         = GAP_BITS + 1;
    localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] MASK       = 16'hB400;

    typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

    state_t          r_state, w_state_nx;
    logic [15:0]     r_lfsr, w_lfsr_nx;
    logic [GW-1:0]   r_gap, w_gap_nx, w_gap_load;
    logic [EW-1:0]   r_edges, w_edges_nx;
    logic [SW-1:0]   r_settle, w_settle_nx;
    logic            r_btn, w_btn_nx, r_busy, r_done, w_done_nx;

    assign w_lfsr_nx  = (r_lfsr >> 1) ^ (r_lfsr[0] ? MASK : 16'h0000);
    assign w_gap_load = GW'(r_lfsr[GAP_BITS-1:0]) + GW'(1);
    assign btn_out    = r_btn;
    assign busy       = r_busy;
    assign done       = r_done;

    // next-state: start a burst on a differing request, toggle on gap expiry, then count out the settle time
    always_comb begin
        w_state_nx  = r_state;
        w_btn_nx    = r_btn;
        w_gap_nx    = r_gap;
        w_edges_nx  = r_edges;
        w_settle_nx = r_settle;
        w_done_nx   = 1'b0;
        case (r_state)
            IDLE: begin
                if (level_in != r_btn) begin
                    w_btn_nx   = ~r_btn;
                    w_edges_nx = EW'(1);
                    w_gap_nx   = w_gap_load;
                    if (BOUNCE_PAIRS == 0) begin
                        w_state_nx  = SETTLE;
                        w_settle_nx = SW'(SETTLE_CYC);
                    end else begin
                        w_state_nx = BOUNCE;
                    end
                end
            end
            BOUNCE: begin
                if (r_gap == GW'(1)) begin
                    w_btn_nx   = ~r_btn;
                    w_edges_nx = r_edges + EW'(1);
                    if (r_edges == EW'(EDGES - 1)) begin
                        w_state_nx  = SETTLE;
                        w_settle_nx = SW'(SETTLE_CYC);
                    end else begin
                        w_gap_nx = w_gap_load;
                    end
                end else begin
                    w_gap_nx = r_gap - GW'(1);
                end
            end
            SETTLE: begin
                if (r_settle == SW'(1)) begin
                    w_state_nx  = IDLE;
                    w_settle_nx = '0;
                    w_done_nx   = 1'b1;
                end else begin
                    w_settle_nx = r_settle - SW'(1);
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // state, counters and LFSR; busy is registered from the next state so it tracks the state exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_lfsr   <= SEED_EFF;
            r_gap    <= '0;
            r_edges  <= '0;
            r_settle <= '0;
            r_btn    <= INIT_LEVEL;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_lfsr   <= w_lfsr_nx;
            r_gap    <= w_gap_nx;
            r_edges  <= w_edges_nx;
            r_settle <= w_settle_nx;
            r_btn    <= w_btn_nx;
            r_busy   <= (w_state_nx != IDLE);
            r_done   <= w_done_nx;
        end
    end
endmodule
